cpu_mem_arbiter: RTL and testbench

//  Shares the single backing-memory port between the instruction-fetch refill path
//  (requester 0, icache) and the data path (requester 1, dcache). Serves one request
//  at a time through a small FSM and returns the full line to the winner with an ack pulse.

---
 rtl/cpu_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_arbiter.sv
// Two-requester arbiter (icache = 0, dcache = 1) sharing one backing-memory line port.
// Define CPU_ARB_DPRIO_EN for fixed dcache priority; otherwise ties are resolved round-robin.
module cpu_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ack,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic [LINE_WIDTH-1:0] rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  grant
);

    // state   | meaning
    // IDLE    | waiting for a request; arbitration and latch happen here
    // BUSY    | memory request outstanding, waiting for mem_ready
    // RESP    | one-cycle ack to the winner, last-winner updated
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_q, last_d;
    logic                    grant_q, grant_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [LINE_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [LINE_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    i_ack_q, i_ack_d;
    logic                    d_ack_q, d_ack_d;
    logic                    winner;

`ifdef CPU_ARB_DPRIO_EN
    // dcache wins whenever it is requesting; last_q is kept but not consulted
    assign winner = d_req;
`else
    // on a tie the requester that lost last time wins; a lone requester always wins
    assign winner = (i_req && d_req) ? ~last_q : d_req;
`endif

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    grant_d   = winner;
                    mem_req_d = 1'b1;
                    if (winner) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        mem_we_d   = 1'b0;
                        mem_addr_d = i_addr;
                    end
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    mem_req_d = 1'b0;
                    if (grant_q) begin
                        d_ack_d = 1'b1;
                    end else begin
                        i_ack_d = 1'b1;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                last_d  = grant_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            grant_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
        end
    end

    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign grant     = grant_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Scoreboard bench for cpu_mem_arbiter: the driver predicts service order and line contents,
// a memory responder and an ack monitor pop and compare independently.
module tb_cpu_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 128;

`ifdef CPU_ARB_DPRIO_EN
    localparam bit DPRIO = 1'b1;
`else
    localparam bit DPRIO = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          i_req, i_ack, d_req, d_we, d_ack;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [LW-1:0] d_wdata, rdata, mem_wdata, mem_rdata;
    logic          mem_req, mem_we, mem_ready, busy, grant;

    cpu_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .grant(grant)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit            id;
        logic [AW-1:0] addr;
        bit            we;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
    } txn_t;

    txn_t mem_q[$];
    txn_t ack_q[$];

    logic [LW-1:0] gmem [logic [AW-1:0]];
    logic [LW-1:0] mstore [logic [AW-1:0]];

    int checks = 0;
    int failures = 0;

    bit            m_last;
    logic [LW-1:0] m_rdata;

    int force_delay = -1;
    bit hold_ready = 1'b0;
    int stray_req_n = 0;
    int stray_done_n = 0;
    int accept_cyc = 0;
    int last_lat = 0;
    bit prev_ack = 1'b0;

    function automatic logic [LW-1:0] dflt(logic [AW-1:0] a);
        return {a ^ 32'hC0DE0000, ~a, a + 32'd7, a ^ 32'h5A5A5A5A};
    endfunction

    function void chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function void fail_now(string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event expected=none (t=%0t)", name, $time);
    endfunction

    // reference: a transaction reads the line as left by every earlier transaction in service order
    function void push_txn(bit id, logic [AW-1:0] addr, bit we, logic [LW-1:0] wdata);
        txn_t t;
        t.id = id;
        t.addr = addr;
        t.we = we;
        t.wdata = wdata;
        if (we) begin
            gmem[addr] = wdata;
            t.rdata = m_rdata;
        end else begin
            t.rdata = gmem.exists(addr) ? gmem[addr] : dflt(addr);
            m_rdata = t.rdata;
        end
        mem_q.push_back(t);
        ack_q.push_back(t);
        m_last = id;
    endfunction

    // memory responder
    bit   active = 1'b0;
    int   wait_cnt = 0;
    txn_t cur;
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clock);
            #1;
            mem_ready = 1'b0;
            if (reset) begin
                active = 1'b0;
                continue;
            end
            if (mem_req && !active) begin
                active = 1'b1;
                wait_cnt = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
                if (mem_q.size() == 0) begin
                    fail_now("unexpected_mem_req");
                    cur.addr = mem_addr; cur.we = mem_we; cur.wdata = mem_wdata;
                end else begin
                    cur = mem_q.pop_front();
                    chk("mem_addr", mem_addr, cur.addr);
                    chk("mem_we", mem_we, cur.we);
                    if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
                end
            end
            if (active) begin
                if (hold_ready) begin
                    // memory stalls
                end else if (wait_cnt == 0) begin
                    chk("mem_addr_stable", mem_addr, cur.addr);
                    chk("mem_we_stable", mem_we, cur.we);
                    mem_ready = 1'b1;
                    accept_cyc = cyc;
                    if (mem_we) begin
                        mstore[mem_addr] = mem_wdata;
                        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                    end else begin
                        mem_rdata = mstore.exists(mem_addr) ? mstore[mem_addr] : dflt(mem_addr);
                    end
                    active = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end else if (stray_req_n != stray_done_n) begin
                mem_ready = 1'b1;
                mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                stray_done_n++;
            end
        end
    end

    // ack monitor
    initial begin
        txn_t t;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_ack = 1'b0;
                continue;
            end
            if (i_ack || d_ack) begin
                chk("ack_exclusive", i_ack & d_ack, 1'b0);
                chk("ack_single_cycle", prev_ack, 1'b0);
                if (ack_q.size() == 0) begin
                    fail_now("unexpected_ack");
                end else begin
                    t = ack_q.pop_front();
                    chk("ack_id", d_ack, t.id);
                    chk("grant", grant, t.id);
                    chk("rdata", rdata, t.rdata);
                    chk("busy_in_ack", busy, 1'b1);
                    chk("ready_to_ack", cyc, accept_cyc + 1);
                end
            end
            prev_ack = i_ack | d_ack;
        end
    end

    task automatic run_round(bit ui, bit ud, logic [AW-1:0] ia, logic [AW-1:0] da,
                             bit dwe, logic [LW-1:0] dwd, int dly, bit scramble);
        bit first;
        bit pend_i, pend_d;
        int start, n;
        force_delay = dly;
        if (ui && ud) first = DPRIO ? 1'b1 : ~m_last;
        else          first = ud;
        if (first) push_txn(1'b1, da, dwe, dwd);
        else       push_txn(1'b0, ia, 1'b0, '0);
        if (ui && ud) begin
            if (first) push_txn(1'b0, ia, 1'b0, '0);
            else       push_txn(1'b1, da, dwe, dwd);
        end
        @(posedge clock);
        #1;
        i_req = ui; i_addr = ia;
        d_req = ud; d_we = dwe; d_addr = da; d_wdata = dwd;
        start = cyc;
        pend_i = ui;
        pend_d = ud;
        n = 0;
        while ((pend_i || pend_d) && n < 100) begin
            @(negedge clock);
            if (i_ack && pend_i) pend_i = 1'b0;
            if (d_ack && pend_d) begin
                pend_d = 1'b0;
                last_lat = cyc - start;
            end
            @(posedge clock);
            #1;
            if (!pend_i) i_req = 1'b0;
            if (!pend_d) d_req = 1'b0;
            if (scramble && mem_req) begin
                if (grant) begin
                    d_addr = $urandom;
                    d_we = ~d_we;
                    d_wdata = {$urandom, $urandom, $urandom, $urandom};
                end else begin
                    i_addr = $urandom;
                end
            end
            n++;
        end
        if (pend_i || pend_d) begin
            fail_now("round_timeout");
            i_req = 1'b0;
            d_req = 1'b0;
        end
    endtask

    initial begin
        logic [AW-1:0] ra, rb;
        logic [LW-1:0] rw;
        int kind, n;
        reset = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        m_last = 1'b1;
        m_rdata = '0;
        repeat (3) @(negedge clock);
        chk("rst_i_ack", i_ack, 1'b0);
        chk("rst_d_ack", d_ack, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_rdata", rdata, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // icache alone, memory answers two cycles after mem_req rises
        run_round(1'b1, 1'b0, 32'h100, '0, 1'b0, '0, 2, 1'b0);
        // dcache write, memory answers in the cycle mem_req rises
        run_round(1'b0, 1'b1, '0, 32'h40, 1'b1, {16{8'hA5}}, 0, 1'b0);
        // ack lands in the third cycle the request is held
        chk("req_to_ack_min", last_lat, 2);

        // simultaneous requests straight after reset
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        m_last = 1'b1;
        m_rdata = '0;
        @(negedge clock);
        run_round(1'b1, 1'b1, 32'h200, 32'h40, 1'b0, '0, 1, 1'b0);
        // both keep requesting: two further tied rounds
        run_round(1'b1, 1'b1, 32'h210, 32'h220, 1'b1, {4{32'h1234_5678}}, -1, 1'b0);
        run_round(1'b1, 1'b1, 32'h220, 32'h210, 1'b0, '0, -1, 1'b0);

        // reset while memory stalls
        hold_ready = 1'b1;
        force_delay = 0;
        push_txn(1'b0, 32'h300, 1'b0, '0);
        @(posedge clock);
        #1;
        i_req = 1'b1;
        i_addr = 32'h300;
        n = 0;
        while (!mem_req && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!mem_req) fail_now("stall_mem_req_timeout");
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_mem_req", mem_req, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_i_ack", i_ack, 1'b0);
        chk("async_rst_d_ack", d_ack, 1'b0);
        i_req = 1'b0;
        ack_q.delete();
        m_last = 1'b1;
        m_rdata = '0;
        repeat (2) @(posedge clock);
        hold_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        run_round(1'b1, 1'b0, 32'h300, '0, 1'b0, '0, 1, 1'b0);

        // mid-transaction input changes, then a stray mem_ready in IDLE
        run_round(1'b0, 1'b1, '0, 32'h80, 1'b0, '0, 3, 1'b1);
        repeat (2) @(negedge clock);
        stray_req_n++;
        repeat (4) begin
            @(negedge clock);
            chk("stray_busy", busy, 1'b0);
            chk("stray_mem_req", mem_req, 1'b0);
        end
        chk("stray_rdata", rdata, m_rdata);

        // randomized traffic over a small address window so lines are reused
        for (int r = 0; r < 40; r++) begin
            kind = int'($urandom_range(0, 2));
            ra = {24'h0, 4'($urandom_range(0, 7)), 4'h0};
            rb = {24'h0, 4'($urandom_range(0, 7)), 4'h0};
            rw = {$urandom, $urandom, $urandom, $urandom};
            run_round(kind != 1, kind != 0, ra, rb, 1'($urandom_range(0, 1)), rw, -1, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) repeat (int'($urandom_range(1, 3))) @(posedge clock);
        end

        repeat (6) @(negedge clock);
        chk("ack_queue_drained", ack_q.size(), 0);
        chk("mem_queue_drained", mem_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
